// File: rtl/bp_l15_pkg.sv
// Shared constants, state encodings and packet layouts for the BP <-> L1.5 miss engine.

`define BP_L15_DATA_PKT_S(idx_w, wy_w, blk_w) \
  struct packed { logic [idx_w-1:0] index; logic [wy_w-1:0] way; logic [blk_w-1:0] line; }

`define BP_L15_TAG_PKT_S(idx_w, wy_w, tg_w) \
  struct packed { logic [idx_w-1:0] index; logic [wy_w-1:0] way; logic [tg_w-1:0] tag; logic [1:0] coh_state; }

`define BP_L15_STAT_PKT_S(idx_w, wy_w) \
  struct packed { logic [idx_w-1:0] index; logic [wy_w-1:0] way; logic clear_dirty; }

package bp_l15_pkg;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;

  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;

  localparam logic [2:0] SZ_1B  = 3'd0;
  localparam logic [2:0] SZ_2B  = 3'd1;
  localparam logic [2:0] SZ_4B  = 3'd2;
  localparam logic [2:0] SZ_8B  = 3'd3;
  localparam logic [2:0] SZ_16B = 3'd7;

  localparam logic [1:0] COH_E = 2'b10;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FILL} state_e;

  typedef enum logic [1:0] {MODE_CACHED, MODE_UC_LOAD, MODE_UC_STORE} req_mode_e;

  // Map an uncached log2-bytes size onto the L1.5 size encoding.
  function automatic logic [2:0] l15_size(input logic [1:0] log2_bytes);
    case (log2_bytes)
      2'd0:    return SZ_1B;
      2'd1:    return SZ_2B;
      2'd2:    return SZ_4B;
      default: return SZ_8B;
    endcase
  endfunction

endpackage

// File: rtl/bp_l15_byteswap64.sv
// Combinational byte reversal of a 64-bit word (BP little-endian <-> L1.5 big-endian).

module bp_l15_byteswap64 (
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  // Byte i of the output takes byte 7-i of the input.
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      data_o[8*i +: 8] = data_i[8*(7-i) +: 8];
    end
  end

endmodule

// File: rtl/bp_l15_miss_engine.sv
// BP D-cache miss engine: multi-beat cached line fills and uncached 1-8B accesses over L1.5.

module bp_l15_miss_engine
  import bp_l15_pkg::*;
#(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned sets_p        = 64,
  parameter int unsigned ways_p        = 8,
  parameter int unsigned block_width_p = 512,
  localparam int unsigned beats_lp     = block_width_p / 128,
  localparam int unsigned offset_w_lp  = $clog2(block_width_p / 8),
  localparam int unsigned index_w_lp   = $clog2(sets_p),
  localparam int unsigned way_w_lp     = $clog2(ways_p),
  localparam int unsigned tag_w_lp     = paddr_width_p - index_w_lp - offset_w_lp
)(
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,

  output logic                                         ready_o,
  input  logic                                         load_miss_i,
  input  logic                                         uncached_load_req_i,
  input  logic                                         uncached_store_req_i,
  input  logic [paddr_width_p-1:0]                     miss_addr_i,
  input  logic [way_w_lp-1:0]                          lru_way_i,
  input  logic [1:0]                                   size_i,
  input  logic [63:0]                                  store_data_i,
  output logic [63:0]                                  uc_data_o,
  output logic                                         uc_data_v_o,

  output logic [4:0]                                   transducer_l15_rqtype,
  output logic [2:0]                                   transducer_l15_size,
  output logic                                         transducer_l15_val,
  output logic [39:0]                                  transducer_l15_address,
  output logic [63:0]                                  transducer_l15_data,
  output logic                                         transducer_l15_nc,
  output logic [3:0]                                   transducer_l15_amo_op,
  output logic                                         transducer_l15_threadid,
  output logic                                         transducer_l15_prefetch,
  output logic                                         transducer_l15_invalidate_cacheline,
  output logic                                         transducer_l15_blockstore,
  output logic                                         transducer_l15_blockinitstore,
  output logic [1:0]                                   transducer_l15_l1rplway,
  output logic [63:0]                                  transducer_l15_data_next_entry,
  output logic [32:0]                                  transducer_l15_csm_data,
  input  logic                                         l15_transducer_ack,

  input  logic                                         l15_transducer_val,
  input  logic [3:0]                                   l15_transducer_returntype,
  input  logic [63:0]                                  l15_transducer_data_0,
  input  logic [63:0]                                  l15_transducer_data_1,
  output logic                                         transducer_l15_req_ack,

  output logic [index_w_lp+way_w_lp+block_width_p-1:0] data_mem_pkt_o,
  output logic                                         data_mem_pkt_v_o,
  input  logic                                         data_mem_pkt_yumi_i,
  output logic [index_w_lp+way_w_lp+tag_w_lp+2-1:0]    tag_mem_pkt_o,
  output logic                                         tag_mem_pkt_v_o,
  input  logic                                         tag_mem_pkt_yumi_i,
  output logic [index_w_lp+way_w_lp+1-1:0]             stat_mem_pkt_o,
  output logic                                         stat_mem_pkt_v_o,
  input  logic                                         stat_mem_pkt_yumi_i
);

  localparam int unsigned cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  typedef `BP_L15_DATA_PKT_S(index_w_lp, way_w_lp, block_width_p) data_pkt_s;
  typedef `BP_L15_TAG_PKT_S(index_w_lp, way_w_lp, tag_w_lp)       tag_pkt_s;
  typedef `BP_L15_STAT_PKT_S(index_w_lp, way_w_lp)                stat_pkt_s;

  state_e                   state_r, state_n;
  req_mode_e                mode_r, req_mode;
  logic [paddr_width_p-1:0] addr_r;
  logic [way_w_lp-1:0]      way_r;
  logic [1:0]               size_r;
  logic [63:0]              st_data_r;
  logic [cnt_w_lp-1:0]      beat_r;
  logic [block_width_p-1:0] line_r;
  logic                     data_sent_r, tag_sent_r, stat_sent_r;

  logic                     req_any, capture, beat_wr, last_beat;
  logic                     ret_fire, ret_match, ret_done, fill_done;
  logic [63:0]              st_data_sw, ret_d0_sw, ret_d1_sw;
  logic [paddr_width_p-1:0] cached_addr;
  data_pkt_s                data_pkt;
  tag_pkt_s                 tag_pkt;
  stat_pkt_s                stat_pkt;

  bp_l15_byteswap64 u_swap_st (.data_i(st_data_r),             .data_o(st_data_sw));
  bp_l15_byteswap64 u_swap_d0 (.data_i(l15_transducer_data_0), .data_o(ret_d0_sw));
  bp_l15_byteswap64 u_swap_d1 (.data_i(l15_transducer_data_1), .data_o(ret_d1_sw));

  assign transducer_l15_amo_op               = '0;
  assign transducer_l15_threadid             = 1'b0;
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_l1rplway             = '0;
  assign transducer_l15_data_next_entry      = '0;
  assign transducer_l15_csm_data             = '0;

  // Request decode, return matching and beat/fill bookkeeping.
  always_comb begin
    req_any     = load_miss_i | uncached_load_req_i | uncached_store_req_i;
    req_mode    = load_miss_i ? MODE_CACHED : (uncached_load_req_i ? MODE_UC_LOAD : MODE_UC_STORE);
    ret_fire    = (state_r == WAIT) && l15_transducer_val;
    ret_match   = (mode_r == MODE_UC_STORE) ? (l15_transducer_returntype == ST_ACK)
                                            : (l15_transducer_returntype == LOAD_RET);
    ret_done    = ret_fire && ret_match;
    last_beat   = (beat_r == cnt_w_lp'(beats_lp - 1));
    // A packet counts as delivered once its yumi has been seen, now or earlier.
    fill_done   = (data_sent_r | data_mem_pkt_yumi_i) & (tag_sent_r | tag_mem_pkt_yumi_i)
                & (stat_sent_r | stat_mem_pkt_yumi_i);
    cached_addr = {addr_r[paddr_width_p-1:offset_w_lp], {offset_w_lp{1'b0}}}
                | (paddr_width_p'(beat_r) << 4);
  end

  // Next-state logic and all L1.5 / BP-side outputs.
  always_comb begin
    state_n                = state_r;
    capture                = 1'b0;
    beat_wr                = 1'b0;
    ready_o                = reset_n_i && (state_r == IDLE);
    transducer_l15_val     = 1'b0;
    transducer_l15_rqtype  = LOAD_RQ;
    transducer_l15_size    = '0;
    transducer_l15_address = '0;
    transducer_l15_data    = '0;
    transducer_l15_nc      = 1'b0;
    transducer_l15_req_ack = 1'b0;
    uc_data_v_o            = 1'b0;
    uc_data_o              = '0;
    data_mem_pkt_v_o       = 1'b0;
    tag_mem_pkt_v_o        = 1'b0;
    stat_mem_pkt_v_o       = 1'b0;
    data_mem_pkt_o         = '0;
    tag_mem_pkt_o          = '0;
    stat_mem_pkt_o         = '0;
    data_pkt               = '{index: addr_r[offset_w_lp +: index_w_lp], way: way_r, line: line_r};
    tag_pkt                = '{index: addr_r[offset_w_lp +: index_w_lp], way: way_r,
                               tag: addr_r[paddr_width_p-1 -: tag_w_lp], coh_state: COH_E};
    stat_pkt               = '{index: addr_r[offset_w_lp +: index_w_lp], way: way_r, clear_dirty: 1'b1};

    case (state_r)
      IDLE: begin
        if (req_any) begin
          capture = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        transducer_l15_val = 1'b1;
        if (mode_r == MODE_CACHED) begin
          transducer_l15_size    = SZ_16B;
          transducer_l15_address = 40'(cached_addr);
        end else begin
          transducer_l15_nc      = 1'b1;
          transducer_l15_size    = l15_size(size_r);
          transducer_l15_address = 40'(addr_r);
        end
        if (mode_r == MODE_UC_STORE) begin
          transducer_l15_rqtype = STORE_RQ;
          transducer_l15_data   = st_data_sw;
        end
        if (l15_transducer_ack) state_n = WAIT;
      end
      WAIT: begin
        transducer_l15_req_ack = l15_transducer_val;
        if (ret_done) begin
          case (mode_r)
            MODE_CACHED: begin
              beat_wr = 1'b1;
              state_n = last_beat ? FILL : SEND;
            end
            MODE_UC_LOAD: begin
              uc_data_v_o = 1'b1;
              uc_data_o   = addr_r[3] ? ret_d1_sw : ret_d0_sw;
              state_n     = IDLE;
            end
            default: state_n = IDLE;
          endcase
        end
      end
      FILL: begin
        data_mem_pkt_v_o = ~data_sent_r;
        tag_mem_pkt_v_o  = ~tag_sent_r;
        stat_mem_pkt_v_o = ~stat_sent_r;
        data_mem_pkt_o   = data_pkt;
        tag_mem_pkt_o    = tag_pkt;
        stat_mem_pkt_o   = stat_pkt;
        if (fill_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  // Request capture, line assembly and per-packet sent flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode_r      <= MODE_CACHED;
      addr_r      <= '0;
      way_r       <= '0;
      size_r      <= '0;
      st_data_r   <= '0;
      beat_r      <= '0;
      line_r      <= '0;
      data_sent_r <= 1'b0;
      tag_sent_r  <= 1'b0;
      stat_sent_r <= 1'b0;
    end else begin
      if (capture) begin
        mode_r      <= req_mode;
        addr_r      <= miss_addr_i;
        way_r       <= lru_way_i;
        size_r      <= size_i;
        st_data_r   <= store_data_i;
        beat_r      <= '0;
        data_sent_r <= 1'b0;
        tag_sent_r  <= 1'b0;
        stat_sent_r <= 1'b0;
      end
      if (beat_wr) begin
        line_r[{beat_r, 7'b0} +: 128] <= {ret_d1_sw, ret_d0_sw};
        beat_r                        <= beat_r + 1'b1;
      end
      if (state_r == FILL) begin
        if (data_mem_pkt_yumi_i) data_sent_r <= 1'b1;
        if (tag_mem_pkt_yumi_i)  tag_sent_r  <= 1'b1;
        if (stat_mem_pkt_yumi_i) stat_sent_r <= 1'b1;
      end
    end
  end

endmodule
